prf_mp: RTL and testbench
=========================

# prf_mp

Parametrised multi-ported physical register file with per-register ready (scoreboard) bits, sitting between the issue stage and the complete/CDB stage. Supports READ_PORTS operand reads with same-cycle writeback forwarding, WRITE_PORTS CDB writebacks, ALLOC_PORTS dispatch allocations that mark destination tags busy, an optional registered read stage, and a flush that restores all ready bits. It replaces the single-write, two-read register file for superscalar configurations.

## Interface
- XLEN, 32, data width
- PHYS_REGS, 64, physical register count; tag width TW = $clog2(PHYS_REGS); tag 0 is hardwired zero
- READ_PORTS, 4, operand read ports
- WRITE_PORTS, 2, writeback ports (CDB width)
- ALLOC_PORTS, 2, dispatch allocation ports
- READ_LATENCY, 0, 0 = combinational read, 1 = registered read

- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- rd_tag  in  READ_PORTS x TW  read tags
- rd_data  out  READ_PORTS x XLEN  read data
- rd_ready  out  READ_PORTS  ready bit of the read tag
- wr_en  in  WRITE_PORTS  write valid
- wr_tag  in  WRITE_PORTS x TW  write tag
- wr_data  in  WRITE_PORTS x XLEN  write data
- alloc_en  in  ALLOC_PORTS  allocate (mark busy) valid
- alloc_tag  in  ALLOC_PORTS x TW  tag being allocated
- flush  in  1  mispredict recovery: set every ready bit
- pending_cnt  out  $clog2(PHYS_REGS+1)  number of tags with ready = 0
- wr_conflict  out  1  sticky: two enabled write ports hit the same nonzero tag in one cycle

## Operation
- Storage: data[1..PHYS_REGS-1], ready[1..PHYS_REGS-1]. Tag 0: reads 0, ready 1; writes and allocs to tag 0 are ignored.
- Write: on each edge, for each port p with wr_en[p] and wr_tag[p] != 0, data[tag] <= wr_data[p], ready[tag] <= 1. Two ports on the same tag: highest-index port wins data; wr_conflict sets and holds until reset.
- Alloc: alloc_en[a], tag != 0 -> ready[tag] <= 0 next edge; data unchanged. Alloc and write to the same tag in one cycle: data is written, ready ends 0 (alloc wins).
- Flush: all ready bits <= 1; overrides alloc in the same cycle; writes in that cycle still update data.
- Read (READ_LATENCY = 0): rd_data/rd_ready combinational from storage, with forwarding: if any enabled write port matches rd_tag (nonzero), rd_data = that port's wr_data (highest index on conflict), rd_ready = 1.
- Read (READ_LATENCY = 1): the forwarded value above is captured at the edge; outputs reflect the rd_tag presented the previous cycle. Allocs in the capture cycle do not affect the captured rd_ready.
- pending_cnt: registered count of ready bits equal to 0 among tags 1..PHYS_REGS-1, updated each edge to the post-update state; never exceeds PHYS_REGS-1.

## Timing
- Reset (reset = 0 at an edge): data all 0, ready all 1, pending_cnt 0, wr_conflict 0, registered read outputs 0 with rd_ready 1. Reset overrides write, alloc and flush in the same cycle; mid-operation reset discards all state.
- Write visible to combinational read in the same cycle via forwarding, and from storage on the next cycle.
- Alloc visible as rd_ready = 0 starting the cycle after the alloc edge.
- READ_LATENCY = 1 adds exactly one cycle from rd_tag to rd_data/rd_ready; no stall, one read per port per cycle.
- pending_cnt lags the triggering alloc/write/flush by one edge.

## Test plan
- Reset, then read all tags on all ports -> rd_data 0, rd_ready 1, pending_cnt 0, wr_conflict 0.
- Alloc tag 5 at cycle 1, read tag 5 at cycle 2 -> rd_ready 0, pending_cnt 1. At cycle 3, wr_en tag 5 = 0xDEADBEEF with a same-cycle read -> rd_data 0xDEADBEEF, rd_ready 1 (forwarded); cycle 4 pending_cnt 0.
- Ports 0 and 1 both write tag 9 (0x11, 0x22) -> data[9] = 0x22, wr_conflict 1 and stays 1 until reset. Write to tag 0 -> reads still 0.
- Alloc tags 3, 4, 7; then flush with a simultaneous alloc of tag 8 -> all rd_ready 1, pending_cnt 0.
- Alloc and write tag 12 in the same cycle -> data[12] = write value, rd_ready 0 next cycle.
- READ_LATENCY = 1: present tag 6 while writing 0x55 to tag 6 -> rd_data 0x55, rd_ready 1 exactly one cycle later.

Source files
------------

// File: rtl/prf_mp.sv
// Multi-ported physical register file with ready bits, write forwarding, allocation and flush.
// Read latency 0 (combinational) or 1 (registered) cycle; no backpressure, one access per port per cycle.
module prf_mp #(
  parameter int XLEN         = 32,
  parameter int PHYS_REGS    = 64,
  parameter int READ_PORTS   = 4,
  parameter int WRITE_PORTS  = 2,
  parameter int ALLOC_PORTS  = 2,
  parameter int READ_LATENCY = 0,
  localparam int TW          = $clog2(PHYS_REGS),
  localparam int CW          = $clog2(PHYS_REGS + 1)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [READ_PORTS-1:0][TW-1:0]       rd_tag,
  output logic [READ_PORTS-1:0][XLEN-1:0]     rd_data,
  output logic [READ_PORTS-1:0]               rd_ready,
  input  logic [WRITE_PORTS-1:0]              wr_en,
  input  logic [WRITE_PORTS-1:0][TW-1:0]      wr_tag,
  input  logic [WRITE_PORTS-1:0][XLEN-1:0]    wr_data,
  input  logic [ALLOC_PORTS-1:0]              alloc_en,
  input  logic [ALLOC_PORTS-1:0][TW-1:0]      alloc_tag,
  input  logic                                flush,
  output logic [CW-1:0]                       pending_cnt,
  output logic                                wr_conflict
);

  logic [XLEN-1:0]                 mem [PHYS_REGS];
  logic [PHYS_REGS-1:0]            rdy;
  logic [PHYS_REGS-1:0]            rdy_nxt;
  logic [CW-1:0]                   busy_nxt;
  logic                            conflict_now;
  logic [READ_PORTS-1:0][XLEN-1:0] fwd_data;
  logic [READ_PORTS-1:0]           fwd_rdy;

  // Writes mark ready, allocs then clear it (alloc wins), flush overrides both.
  always_comb begin
    rdy_nxt = rdy;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      if (wr_en[p] && (wr_tag[p] != '0)) begin
        rdy_nxt[wr_tag[p]] = 1'b1;
      end
    end
    for (int a = 0; a < ALLOC_PORTS; a++) begin
      if (alloc_en[a] && (alloc_tag[a] != '0)) begin
        rdy_nxt[alloc_tag[a]] = 1'b0;
      end
    end
    if (flush) begin
      rdy_nxt = '1;
    end
    rdy_nxt[0] = 1'b1;
  end

  always_comb begin
    busy_nxt = '0;
    for (int i = 1; i < PHYS_REGS; i++) begin
      if (!rdy_nxt[i]) begin
        busy_nxt = busy_nxt + CW'(1);
      end
    end
  end

  always_comb begin
    conflict_now = 1'b0;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      for (int q = p + 1; q < WRITE_PORTS; q++) begin
        if (wr_en[p] && wr_en[q] && (wr_tag[p] == wr_tag[q]) && (wr_tag[p] != '0)) begin
          conflict_now = 1'b1;
        end
      end
    end
  end

  // Ports are applied in ascending order so the highest-index writer lands last.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (wr_en[p] && (wr_tag[p] != '0)) begin
          mem[wr_tag[p]] <= wr_data[p];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rdy         <= '1;
      pending_cnt <= '0;
      wr_conflict <= 1'b0;
    end else begin
      rdy         <= rdy_nxt;
      pending_cnt <= busy_nxt;
      wr_conflict <= wr_conflict | conflict_now;
    end
  end

  always_comb begin
    for (int r = 0; r < READ_PORTS; r++) begin
      fwd_data[r] = (rd_tag[r] == '0) ? '0 : mem[rd_tag[r]];
      fwd_rdy[r]  = (rd_tag[r] == '0) ? 1'b1 : rdy[rd_tag[r]];
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (wr_en[p] && (wr_tag[p] == rd_tag[r]) && (rd_tag[r] != '0)) begin
          fwd_data[r] = wr_data[p];
          fwd_rdy[r]  = 1'b1;
        end
      end
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb_read
      assign rd_data  = fwd_data;
      assign rd_ready = fwd_rdy;
    end else begin : g_reg_read
      always_ff @(posedge clock) begin
        if (!reset) begin
          rd_data  <= '0;
          rd_ready <= '1;
        end else begin
          rd_data  <= fwd_data;
          rd_ready <= fwd_rdy;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_prf_mp.sv
// Drives a combinational-read and a registered-read instance with shared stimulus and
// compares both against a behavioural register-file model.
module tb_prf_mp;
  localparam int XLEN = 32;
  localparam int PR   = 64;
  localparam int TW   = 6;
  localparam int CW   = 7;
  localparam int RP   = 4;
  localparam int WP   = 2;
  localparam int AP   = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                    reset;
  logic [RP-1:0][TW-1:0]   rd_tag;
  logic [WP-1:0]           wr_en;
  logic [WP-1:0][TW-1:0]   wr_tag;
  logic [WP-1:0][XLEN-1:0] wr_data;
  logic [AP-1:0]           alloc_en;
  logic [AP-1:0][TW-1:0]   alloc_tag;
  logic                    flush;

  logic [RP-1:0][XLEN-1:0] rd_data0, rd_data1;
  logic [RP-1:0]           rd_ready0, rd_ready1;
  logic [CW-1:0]           pending_cnt0, pending_cnt1;
  logic                    wr_conflict0, wr_conflict1;

  prf_mp #(.READ_LATENCY(0)) u_l0 (
    .clock(clock), .reset(reset), .rd_tag(rd_tag), .rd_data(rd_data0), .rd_ready(rd_ready0),
    .wr_en(wr_en), .wr_tag(wr_tag), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_tag(alloc_tag), .flush(flush), .pending_cnt(pending_cnt0), .wr_conflict(wr_conflict0));

  prf_mp #(.READ_LATENCY(1)) u_l1 (
    .clock(clock), .reset(reset), .rd_tag(rd_tag), .rd_data(rd_data1), .rd_ready(rd_ready1),
    .wr_en(wr_en), .wr_tag(wr_tag), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_tag(alloc_tag), .flush(flush), .pending_cnt(pending_cnt1), .wr_conflict(wr_conflict1));

  // Reference state: register contents, ready flags, sticky conflict, previous-cycle read result.
  logic [XLEN-1:0] md [PR];
  bit              mr [PR];
  bit              mconf;
  int              mcnt;
  logic [XLEN-1:0] cap_d [RP];
  bit              cap_r [RP];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // What a reader of tag rd_tag[r] should see this cycle: the latest writer in port order, else storage.
  task automatic expect_read(input int r, output logic [XLEN-1:0] d, output bit rd);
    int t;
    t = int'(rd_tag[r]);
    if (t == 0) begin
      d = '0; rd = 1'b1;
    end else begin
      d = md[t]; rd = mr[t];
      for (int p = WP - 1; p >= 0; p--) begin
        if (wr_en[p] && int'(wr_tag[p]) == t) begin
          d = wr_data[p]; rd = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < PR; i++) begin
      md[i] = '0; mr[i] = 1'b1;
    end
    mconf = 1'b0;
    mcnt  = 0;
    for (int r = 0; r < RP; r++) begin
      cap_d[r] = '0; cap_r[r] = 1'b1;
    end
  endtask

  task automatic idle();
    reset = 1'b1; flush = 1'b0; wr_en = '0; alloc_en = '0;
    rd_tag = '0; wr_tag = '0; wr_data = '0; alloc_tag = '0;
  endtask

  // Called at a negedge with inputs already set; checks, takes one clock edge, updates the model.
  task automatic cycle();
    logic [XLEN-1:0] nd [RP];
    bit              nr [RP];
    #1;
    for (int r = 0; r < RP; r++) begin
      expect_read(r, nd[r], nr[r]);
      chk($sformatf("l0_rd_data[%0d] tag %0d", r, rd_tag[r]), 64'(rd_data0[r]), 64'(nd[r]));
      chk($sformatf("l0_rd_ready[%0d] tag %0d", r, rd_tag[r]), 64'(rd_ready0[r]), 64'(nr[r]));
      chk($sformatf("l1_rd_data[%0d]", r), 64'(rd_data1[r]), 64'(cap_d[r]));
      chk($sformatf("l1_rd_ready[%0d]", r), 64'(rd_ready1[r]), 64'(cap_r[r]));
    end
    chk("l0_pending_cnt", 64'(pending_cnt0), 64'(mcnt));
    chk("l1_pending_cnt", 64'(pending_cnt1), 64'(mcnt));
    chk("l0_wr_conflict", 64'(wr_conflict0), 64'(mconf));
    chk("l1_wr_conflict", 64'(wr_conflict1), 64'(mconf));
    @(posedge clock);
    if (!reset) begin
      model_reset();
    end else begin
      for (int r = 0; r < RP; r++) begin
        cap_d[r] = nd[r]; cap_r[r] = nr[r];
      end
      for (int p = 0; p < WP; p++) begin
        for (int q = p + 1; q < WP; q++) begin
          if (wr_en[p] && wr_en[q] && wr_tag[p] == wr_tag[q] && wr_tag[p] != 0) mconf = 1'b1;
        end
      end
      for (int p = 0; p < WP; p++) begin
        if (wr_en[p] && wr_tag[p] != 0) begin
          md[wr_tag[p]] = wr_data[p]; mr[wr_tag[p]] = 1'b1;
        end
      end
      if (flush) begin
        for (int i = 0; i < PR; i++) mr[i] = 1'b1;
      end else begin
        for (int a = 0; a < AP; a++) begin
          if (alloc_en[a] && alloc_tag[a] != 0) mr[alloc_tag[a]] = 1'b0;
        end
      end
      mcnt = 0;
      for (int i = 1; i < PR; i++) mcnt += (mr[i] ? 0 : 1);
    end
    @(negedge clock);
  endtask

  initial begin
    idle();
    reset = 1'b0;
    @(posedge clock);
    @(posedge clock);
    model_reset();
    @(negedge clock);
    reset = 1'b1;

    // Every tag on every port straight after reset.
    for (int i = 0; i < PR / RP; i++) begin
      idle();
      for (int r = 0; r < RP; r++) rd_tag[r] = TW'(i * RP + r);
      cycle();
    end

    // Alloc tag 5, observe busy, then forwarded writeback.
    idle(); alloc_en[0] = 1'b1; alloc_tag[0] = 6'd5; cycle();
    idle(); rd_tag[0] = 6'd5;
    chk("plan_pending_after_alloc", 64'(pending_cnt0), 64'd1);
    cycle();
    idle(); rd_tag[0] = 6'd5; wr_en[0] = 1'b1; wr_tag[0] = 6'd5; wr_data[0] = 32'hDEADBEEF; cycle();
    idle(); rd_tag[1] = 6'd5;
    chk("plan_pending_after_wb", 64'(pending_cnt0), 64'd0);
    cycle();

    // Same-tag write conflict, then write to tag 0.
    idle(); wr_en = 2'b11; wr_tag[0] = 6'd9; wr_tag[1] = 6'd9;
    wr_data[0] = 32'h11; wr_data[1] = 32'h22; cycle();
    idle(); rd_tag[2] = 6'd9;
    chk("plan_conflict_set", 64'(wr_conflict0), 64'd1);
    cycle();
    idle(); wr_en[1] = 1'b1; wr_tag[1] = 6'd0; wr_data[1] = 32'h77; rd_tag[3] = 6'd0; cycle();
    idle(); rd_tag[3] = 6'd0; cycle();

    // Allocs, then flush with a simultaneous alloc.
    idle(); alloc_en = 2'b11; alloc_tag[0] = 6'd3; alloc_tag[1] = 6'd4; cycle();
    idle(); alloc_en[1] = 1'b1; alloc_tag[1] = 6'd7; cycle();
    idle(); flush = 1'b1; alloc_en[0] = 1'b1; alloc_tag[0] = 6'd8;
    rd_tag[0] = 6'd3; rd_tag[1] = 6'd4; rd_tag[2] = 6'd7; rd_tag[3] = 6'd8;
    chk("plan_pending_before_flush", 64'(pending_cnt0), 64'd3);
    cycle();
    idle(); rd_tag[0] = 6'd3; rd_tag[1] = 6'd4; rd_tag[2] = 6'd7; rd_tag[3] = 6'd8;
    chk("plan_pending_after_flush", 64'(pending_cnt0), 64'd0);
    cycle();

    // Alloc and write of the same tag: data lands, tag stays busy.
    idle(); alloc_en[0] = 1'b1; alloc_tag[0] = 6'd12; wr_en[0] = 1'b1; wr_tag[0] = 6'd12;
    wr_data[0] = 32'hCAFE0012; cycle();
    idle(); rd_tag[0] = 6'd12; cycle();

    // Registered read of a tag written in the same cycle.
    idle(); rd_tag[1] = 6'd6; wr_en[1] = 1'b1; wr_tag[1] = 6'd6; wr_data[1] = 32'h55; cycle();
    idle();
    chk("plan_l1_fwd_data", 64'(rd_data1[1]), 64'h55);
    chk("plan_l1_fwd_ready", 64'(rd_ready1[1]), 64'd1);
    cycle();

    // Randomised traffic on a narrow tag range to provoke collisions, with rare flush and reset.
    for (int n = 0; n < 600; n++) begin
      idle();
      reset = ($urandom_range(0, 149) != 0);
      flush = ($urandom_range(0, 24) == 0);
      for (int r = 0; r < RP; r++)
        rd_tag[r] = ($urandom_range(0, 3) == 0) ? TW'($urandom_range(0, PR - 1)) : TW'($urandom_range(0, 15));
      for (int p = 0; p < WP; p++) begin
        wr_en[p]   = ($urandom_range(0, 2) == 0);
        wr_tag[p]  = TW'($urandom_range(0, 15));
        wr_data[p] = $urandom;
      end
      for (int a = 0; a < AP; a++) begin
        alloc_en[a]  = ($urandom_range(0, 1) == 0);
        alloc_tag[a] = TW'($urandom_range(0, 15));
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
